// File: rtl/shift_reg_pkg.sv
// Shared types and the single-step shift/rotate function for univ_shift_register.
// Supports register widths up to MAX_W bits.
package shift_reg_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_SHL = 2'b00,
        MODE_SHR = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        logic  serial;
        word_t q;
    } step_t;

    // q must arrive zero-extended above bit width-1; the result keeps that property.
    function automatic step_t shift_step(word_t q, int unsigned width, mode_e mode, logic din);
        step_t r;
        word_t mask;
        word_t msb_aligned;
        logic  out_bit;
        logic  in_bit;
        mask        = (word_t'(1) << width) - word_t'(1);
        msb_aligned = q >> (width - 1);
        out_bit     = (mode == MODE_SHL || mode == MODE_ROL) ? msb_aligned[0] : q[0];
        in_bit      = mode[1] ? out_bit : din;
        if (mode == MODE_SHL || mode == MODE_ROL)
            r.q = ((q << 1) | word_t'(in_bit)) & mask;
        else
            r.q = (q >> 1) | (word_t'(in_bit) << (width - 1));
        r.serial = out_bit;
        return r;
    endfunction

endpackage

// File: rtl/univ_shift_register.sv
// Universal shift/rotate register with single-step, N-step burst and parallel load.
// Optional PARITY output (XOR of q) when SHIFT_REG_PARITY_EN is defined.
module univ_shift_register
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] PDATA,
    input  logic             SHIFT_ENABLE,
    input  logic [1:0]       MODE,
    input  logic             DATA_IN,
    input  logic             BURST_START,
    input  logic [LEN_W-1:0] BURST_LEN,
    output logic [WIDTH-1:0] q,
    output logic             SERIAL_OUT,
    output logic             BUSY,
    output logic             DONE
`ifdef SHIFT_REG_PARITY_EN
    ,
    output logic             PARITY
`endif
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_e           state;
    mode_e            mode_r;
    mode_e            step_mode;
    logic [LEN_W-1:0] cnt;
    step_t            nxt;
    logic [WIDTH-1:0] nxt_q;

    always_comb begin
        step_mode = (state == ST_BURST) ? mode_r : mode_e'(MODE);
        nxt       = shift_step(word_t'(q), WIDTH, step_mode, DATA_IN);
        nxt_q     = nxt.q[WIDTH-1:0];
    end

    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^nxt.q[MAX_W-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q          <= '0;
            SERIAL_OUT <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            state      <= ST_IDLE;
            mode_r     <= MODE_SHL;
            cnt        <= '0;
        end else begin
            DONE <= 1'b0;
            if (LOAD) begin
                // Load wins in either state; an aborted burst gets no DONE.
                q     <= PDATA;
                state <= ST_IDLE;
                BUSY  <= 1'b0;
                cnt   <= '0;
            end else if (state == ST_BURST) begin
                q          <= nxt_q;
                SERIAL_OUT <= nxt.serial;
                cnt        <= cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
            end else if (BURST_START) begin
                if (BURST_LEN == '0) begin
                    DONE <= 1'b1;
                end else begin
                    cnt    <= (BURST_LEN > WIDTH_L) ? WIDTH_L : BURST_LEN;
                    mode_r <= mode_e'(MODE);
                    state  <= ST_BURST;
                    BUSY   <= 1'b1;
                end
            end else if (SHIFT_ENABLE) begin
                q          <= nxt_q;
                SERIAL_OUT <= nxt.serial;
            end
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    always_comb PARITY = ^q;
`endif

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register (WIDTH=8): directed cases plus random traffic
// against an arithmetic reference model.
module tb_univ_shift_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             LOAD;
    logic [WIDTH-1:0] PDATA;
    logic             SHIFT_ENABLE;
    logic [1:0]       MODE;
    logic             DATA_IN;
    logic             BURST_START;
    logic [LEN_W-1:0] BURST_LEN;
    logic [WIDTH-1:0] q;
    logic             SERIAL_OUT;
    logic             BUSY;
    logic             DONE;
`ifdef SHIFT_REG_PARITY_EN
    logic             PARITY;
`endif

    univ_shift_register #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD), .PDATA(PDATA),
        .SHIFT_ENABLE(SHIFT_ENABLE), .MODE(MODE), .DATA_IN(DATA_IN),
        .BURST_START(BURST_START), .BURST_LEN(BURST_LEN), .q(q),
        .SERIAL_OUT(SERIAL_OUT), .BUSY(BUSY), .DONE(DONE)
`ifdef SHIFT_REG_PARITY_EN
        , .PARITY(PARITY)
`endif
    );

    always #5 CLK = ~CLK;

    int nassert = 0;
    int nfail   = 0;

    // Reference model: register as an integer 0..255, burst as "steps remaining".
    int m_q, m_so, m_rem, m_mode, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".serial_out"}, 32'(SERIAL_OUT), 32'(m_so));
        chk({tag, ".busy"}, 32'(BUSY), 32'(m_rem > 0));
        chk({tag, ".done"}, 32'(DONE), 32'(m_done));
`ifdef SHIFT_REG_PARITY_EN
        chk({tag, ".parity"}, 32'(PARITY), 32'($countones(m_q[7:0]) % 2));
`endif
    endtask

    function automatic void model_step(input int mode, input int din);
        case (mode)
            0: begin m_so = m_q / 128; m_q = (m_q * 2 + din) % 256;   end
            1: begin m_so = m_q % 2;   m_q = m_q / 2 + din * 128;     end
            2: begin m_so = m_q / 128; m_q = (m_q * 2 + m_so) % 256;  end
            default: begin m_so = m_q % 2; m_q = m_q / 2 + m_so * 128; end
        endcase
    endfunction

    function automatic void model_reset();
        m_q = 0; m_so = 0; m_rem = 0; m_mode = 0; m_done = 0;
    endfunction

    function automatic void model_edge();
        m_done = 0;
        if (LOAD) begin
            m_q   = int'(PDATA);
            m_rem = 0;
        end else if (m_rem > 0) begin
            model_step(m_mode, int'(DATA_IN));
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (BURST_START) begin
            if (BURST_LEN == 0) m_done = 1;
            else begin
                m_rem  = (int'(BURST_LEN) > 8) ? 8 : int'(BURST_LEN);
                m_mode = int'(MODE);
            end
        end else if (SHIFT_ENABLE) begin
            model_step(int'(MODE), int'(DATA_IN));
        end
    endfunction

    task automatic drive(input logic ld, input logic [7:0] pd, input logic sh, input logic [1:0] md,
                         input logic din, input logic bs, input logic [LEN_W-1:0] bl);
        LOAD = ld; PDATA = pd; SHIFT_ENABLE = sh; MODE = md; DATA_IN = din;
        BURST_START = bs; BURST_LEN = bl;
    endtask

    task automatic clk_step(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic idle_step(input string tag);
        drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        clk_step(tag);
    endtask

    initial begin
        RESET_N = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        model_reset();
        #3;
        check_all("reset");
        #9 RESET_N = 1'b1;

        // Single shift-left
        drive(1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("load_a5");
        drive(1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, '0); clk_step("shl");
        chk("shl_q_const", 32'(q), 32'h4B);
        chk("shl_so_const", 32'(SERIAL_OUT), 32'd1);

        // Rotate-right burst of 3
        drive(1'b1, 8'h81, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("load_81");
        drive(1'b0, 8'h00, 1'b0, 2'b11, 1'b0, 1'b1, 4'd3); clk_step("ror_start");
        chk("ror_busy_k", 32'(BUSY), 32'd1);
        idle_step("ror_1");
        idle_step("ror_2");
        idle_step("ror_3");
        chk("ror_q_const", 32'(q), 32'h30);
        chk("ror_done_const", 32'(DONE), 32'd1);
        idle_step("ror_after");

        // Clamped rotate-left burst, with ignored inputs thrown at it
        drive(1'b1, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("load_3c");
        drive(1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b1, 4'd12); clk_step("rol_start");
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 2'b01, 1'($urandom), 1'b1, 4'd2);
            clk_step("rol_step");
        end
        chk("rol_q_const", 32'(q), 32'h3C);
        chk("rol_done_const", 32'(DONE), 32'd1);
        // New burst accepted in the DONE cycle
        drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1, 4'd1); clk_step("back2back");
        idle_step("back2back_end");

        // Zero-length burst
        drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0); clk_step("zero_start");
        chk("zero_busy", 32'(BUSY), 32'd0);
        idle_step("zero_after");

        // Load aborts a burst
        drive(1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b1, 4'd5); clk_step("abort_start");
        idle_step("abort_1");
        drive(1'b1, 8'h0F, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("abort_load");
        chk("abort_q_const", 32'(q), 32'h0F);
        idle_step("abort_nodone");
        chk("abort_done_const", 32'(DONE), 32'd0);

`ifdef SHIFT_REG_PARITY_EN
        drive(1'b1, 8'h07, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("par_07");
        chk("parity_07", 32'(PARITY), 32'd1);
        drive(1'b1, 8'h03, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("par_03");
        chk("parity_03", 32'(PARITY), 32'd0);
`endif

        // Asynchronous reset mid-burst
        drive(1'b1, 8'hFF, 1'b0, 2'b00, 1'b0, 1'b0, '0); clk_step("load_ff");
        drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 4'd5); clk_step("rst_burst");
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset_q_const", 32'(q), 32'h00);
        RESET_N = 1'b1;
        idle_step("post_reset");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 11) == 0), 8'($urandom), ($urandom_range(0, 1) == 1),
                  2'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom));
            clk_step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width (legal >= 2).
REQ-002 The block SHALL have parameter LEN_W, default $clog2(WIDTH+1), width of BURST_LEN.
REQ-003 The block SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port LOAD  input  1  parallel load request.
REQ-006 The block SHALL have port PDATA  input  WIDTH  parallel load data.
REQ-007 The block SHALL have port SHIFT_ENABLE  input  1  single-step shift request.
REQ-008 The block SHALL have port MODE  input  2  00 shift-left, 01 shift-right, 10 rotate-left, 11 rotate-right.
REQ-009 The block SHALL have port DATA_IN  input  1  serial input.
REQ-010 The block SHALL have port BURST_START  input  1  start an N-step burst.
REQ-011 The block SHALL have port BURST_LEN  input  LEN_W  burst step count N.
REQ-012 The block SHALL have port q  output  WIDTH  register contents.
REQ-013 The block SHALL have port SERIAL_OUT  output  1  bit shifted out on the most recent shift step.
REQ-014 The block SHALL have port BUSY  output  1  burst in progress.
REQ-015 The block SHALL have port DONE  output  1  one-cycle burst-complete pulse.

Function
REQ-016 Shift-left SHALL move q[i] to q[i+1], load DATA_IN into q[0] and set SERIAL_OUT to the old q[WIDTH-1].
REQ-017 Shift-right SHALL move q[i+1] to q[i], load DATA_IN into q[WIDTH-1] and set SERIAL_OUT to the old q[0].
REQ-018 Rotates SHALL behave as the shifts, with the outgoing bit replacing DATA_IN; SERIAL_OUT SHALL equal the outgoing bit.
REQ-019 FSM states SHALL be IDLE and BURST.
REQ-020 Priority in IDLE SHALL be LOAD > BURST_START > SHIFT_ENABLE > hold.
REQ-021 LOAD SHALL set q=PDATA at the next edge and leave SERIAL_OUT unchanged.
REQ-022 SHIFT_ENABLE in IDLE SHALL perform exactly one step per asserted edge using the live MODE.
REQ-023 BURST_START at edge k with N>0 SHALL latch MODE and min(N,WIDTH) into the counter and enter BURST; BUSY SHALL be 1 after edge k.
REQ-024 In BURST, one step per edge SHALL occur at edges k+1..k+N, using the latched MODE and the live DATA_IN.
REQ-025 After edge k+N the FSM SHALL be in IDLE with BUSY=0 and DONE=1 for exactly one cycle.
REQ-026 BURST_LEN=0 at BURST_START SHALL perform no shift, keep BUSY=0 and pulse DONE in the following cycle.
REQ-027 BURST_LEN>WIDTH SHALL be clamped to WIDTH.
REQ-028 In BURST, SHIFT_ENABLE, BURST_START and MODE SHALL be ignored.
REQ-029 LOAD in BURST SHALL abort the burst: load PDATA, return to IDLE, with no DONE pulse.
REQ-030 A BURST_START in the DONE cycle SHALL be accepted as a new burst.

Reset
REQ-031 RESET_N low SHALL immediately force q=0, SERIAL_OUT=0, BUSY=0, DONE=0, state IDLE and counter=0, including mid-burst.
REQ-032 After RESET_N deasserts, operation SHALL resume at the first rising CLK edge.

Configuration
REQ-033 With SHIFT_REG_PARITY_EN defined, output PARITY (1 bit) SHALL exist and equal XOR of q, combinationally; without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package shift_reg_pkg SHALL hold the mode enum (MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR) and the state enum (ST_IDLE, ST_BURST).
REQ-035 The block SHALL be a single module with no sub-module; the next-value step logic SHALL be one function in shift_reg_pkg.

Verification (WIDTH=8)
REQ-036 LOAD PDATA=A5, then one SHIFT_ENABLE with MODE=00 and DATA_IN=1 -> q=4B, SERIAL_OUT=1.
REQ-037 LOAD 81, then BURST_START with MODE=11 and BURST_LEN=3 -> BUSY high for 3 cycles, q=30, DONE pulses once.
REQ-038 LOAD 3C, then BURST_START with MODE=10 and BURST_LEN=12 -> 8 steps, q=3C, DONE after the 8th step.
REQ-039 Burst with BURST_LEN=0 -> q unchanged, BUSY=0, one DONE pulse; LOAD 0F during a burst -> q=0F, BUSY=0, no DONE.
REQ-040 RESET_N low mid-burst (q=FF) -> q=00, BUSY=0, DONE=0 before the next clock edge.
REQ-041 With SHIFT_REG_PARITY_EN defined, LOAD 07 -> PARITY=1; LOAD 03 -> PARITY=0.
